// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// Holds the arbiter state encoding and the grant-pointer width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first eligible index strictly after
// last_grant, wrapping modulo NUM_REQ.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   last_grant,
  output logic               found,
  output logic [PTR_W-1:0]   index
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest eligible wins.
  always_comb begin
    found = |eligible;
    index = '0;
    cand  = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(last_grant) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (eligible[cand]) index = PTR_W'(cand);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a packet burst of
// up to MAX_BEATS words into a downstream FIFO.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ-1:0]         req_mask_i,
  input  logic                       fifo_full_i,
  output logic                       fifo_wr_en_o,
  output logic [WIDTH-1:0]           fifo_write_data_o,
  output logic                       grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t         state, state_nxt;
  logic [PTR_W-1:0]   grant_q, grant_nxt;
  logic [PTR_W-1:0]   last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [NUM_REQ-1:0] ready;
  logic               beat;
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .eligible   (req_valid_i & req_mask_i),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= PTR_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  assign beat = (state == BUSY) && req_valid_i[grant_q] && !fifo_full_i;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_q;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    ready          = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        ready[grant_q] = !fifo_full_i;
        if (beat) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (req_last_i[grant_q] || (beat_cnt == CNT_W'(MAX_BEATS - 1))) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant_q;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted so an aborted packet
  // cannot push one more word before the state register clears.
  assign req_ready_o       = rst_n ? ready : '0;
  assign fifo_wr_en_o      = rst_n && beat;
  assign fifo_write_data_o = rst_n ? req_data_i[int'(grant_q)*WIDTH +: WIDTH] : '0;
  assign grant_valid_o     = rst_n && (state == BUSY);
  assign grant_id_o        = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change and outputs are checked
// mid-cycle on the falling edge; FIFO writes are logged on the rising edge.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_last_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       req_mask_i;
  logic                     fifo_full_i;
  logic                     fifo_wr_en_o;
  logic [WIDTH-1:0]         fifo_write_data_o;
  logic                     grant_valid_o;
  logic [1:0]               grant_id_o;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] wr_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_BEATS(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_data_i        (req_data_i),
    .req_last_i        (req_last_i),
    .req_ready_o       (req_ready_o),
    .req_mask_i        (req_mask_i),
    .fifo_full_i       (fifo_full_i),
    .fifo_wr_en_o      (fifo_wr_en_o),
    .fifo_write_data_o (fifo_write_data_o),
    .grant_valid_o     (grant_valid_o),
    .grant_id_o        (grant_id_o)
  );

  always @(posedge clk) if (fifo_wr_en_o) wr_q.push_back(fifo_write_data_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_word(input int idx, input logic [WIDTH-1:0] val);
    req_data_i[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] id, input logic [WIDTH-1:0] data);
    chk({tag, "_gv"}, grant_valid_o, 1);
    chk({tag, "_gid"}, grant_id_o, id);
    chk({tag, "_wr"}, fifo_wr_en_o, 1);
    chk({tag, "_data"}, fifo_write_data_o, data);
    chk({tag, "_rdy"}, req_ready_o, 4'b0001 << id);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gv"}, grant_valid_o, 0);
    chk({tag, "_wr"}, fifo_wr_en_o, 0);
    chk({tag, "_rdy"}, req_ready_o, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid_i = '0;
    req_data_i  = 32'h5A5A_5A5A;
    req_last_i  = '0;
    req_mask_i  = 4'hF;
    fifo_full_i = 1'b0;

    // Reset: outputs low even with data present on the inputs
    next_cyc(); req_valid_i = 4'b0001; settle();
    chk("rst_rdy", req_ready_o, 0);
    chk("rst_wr", fifo_wr_en_o, 0);
    chk("rst_data", fifo_write_data_o, 0);
    chk("rst_gv", grant_valid_o, 0);
    next_cyc(); settle();
    chk("rst_gid", grant_id_o, 0);

    // Alternating single-beat grants 0,2,0,2 with one idle cycle between
    next_cyc();
    rst_n = 1'b1; req_valid_i = 4'b0101; req_last_i = 4'hF;
    set_word(0, 8'h10); set_word(2, 8'h30);
    settle(); chk_idle("rr_first_idle");
    for (int k = 0; k < 4; k++) begin
      next_cyc(); settle();
      chk_beat("rr_grant", (k % 2) ? 2'd2 : 2'd0, (k % 2) ? 8'h30 : 8'h10);
      next_cyc();
      if (k == 3) req_valid_i = '0;
      settle(); chk_idle("rr_gap");
    end

    // Three-word packet from requester 1 while requester 3 waits
    wr_q.delete();
    req_valid_i = 4'b0010; req_last_i = 4'b0000; set_word(1, 8'hA1);
    next_cyc();
    req_valid_i = 4'b1010; req_last_i = 4'b1000; set_word(3, 8'hD3);
    settle(); chk_beat("pkt_a1", 2'd1, 8'hA1);
    next_cyc(); set_word(1, 8'hA2); settle(); chk_beat("pkt_a2", 2'd1, 8'hA2);
    next_cyc(); set_word(1, 8'hA3); req_last_i = 4'b1010; settle();
    chk_beat("pkt_a3", 2'd1, 8'hA3);
    next_cyc(); req_valid_i = 4'b1000; settle(); chk_idle("pkt_gap");
    next_cyc(); settle(); chk_beat("pkt_r3", 2'd3, 8'hD3);
    next_cyc(); req_valid_i = '0; settle(); chk_idle("pkt_end");
    chk("pkt_qlen", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      chk("pkt_q0", wr_q[0], 8'hA1);
      chk("pkt_q1", wr_q[1], 8'hA2);
      chk("pkt_q2", wr_q[2], 8'hA3);
      chk("pkt_q3", wr_q[3], 8'hD3);
    end

    // Requester 0 streams without last: released after 16 beats, then 2
    wr_q.delete();
    req_valid_i = 4'b0101; req_last_i = 4'b0000;
    set_word(0, 8'h40); set_word(2, 8'h55);
    for (int k = 0; k < 16; k++) begin
      next_cyc(); set_word(0, 8'h40 + 8'(k)); settle();
      chk_beat("max_beat", 2'd0, 8'h40 + 8'(k));
    end
    next_cyc(); req_last_i = 4'b0100; settle(); chk_idle("max_release");
    next_cyc(); settle(); chk_beat("max_next", 2'd2, 8'h55);
    next_cyc(); req_valid_i = '0; settle(); chk_idle("max_end");
    chk("max_qlen", wr_q.size(), 17);

    // Back-pressure: full for 5 cycles in the middle of a 4-word packet
    wr_q.delete();
    req_valid_i = 4'b1000; req_last_i = 4'b0000; set_word(3, 8'h70);
    next_cyc(); settle(); chk_beat("full_w0", 2'd3, 8'h70);
    next_cyc(); set_word(3, 8'h71); settle(); chk_beat("full_w1", 2'd3, 8'h71);
    for (int k = 0; k < 5; k++) begin
      next_cyc(); set_word(3, 8'h72); fifo_full_i = 1'b1; settle();
      chk("full_wr", fifo_wr_en_o, 0);
      chk("full_rdy", req_ready_o, 0);
      chk("full_gv", grant_valid_o, 1);
    end
    next_cyc(); fifo_full_i = 1'b0; settle(); chk_beat("full_w2", 2'd3, 8'h72);
    next_cyc(); set_word(3, 8'h73); req_last_i = 4'b1000; settle();
    chk_beat("full_w3", 2'd3, 8'h73);
    next_cyc(); req_valid_i = '0; settle(); chk_idle("full_end");
    chk("full_qlen", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      chk("full_q0", wr_q[0], 8'h70);
      chk("full_q1", wr_q[1], 8'h71);
      chk("full_q2", wr_q[2], 8'h72);
      chk("full_q3", wr_q[3], 8'h73);
    end

    // Masked requester is ignored until its mask bit is set
    req_mask_i = 4'b1011; req_valid_i = 4'b0100; req_last_i = 4'b0100;
    set_word(2, 8'h62);
    next_cyc(); settle(); chk_idle("mask_off1");
    next_cyc(); req_mask_i = 4'hF; settle(); chk_idle("mask_off2");
    next_cyc(); settle(); chk_beat("mask_on", 2'd2, 8'h62);
    next_cyc(); req_valid_i = '0; settle(); chk_idle("mask_end");

    // Reset during word 2 aborts the packet; then lowest valid index wins
    wr_q.delete();
    req_valid_i = 4'b0010; req_last_i = 4'b0000; set_word(1, 8'h81);
    next_cyc(); settle(); chk_beat("abort_w1", 2'd1, 8'h81);
    next_cyc(); set_word(1, 8'h82); rst_n = 1'b0; settle();
    chk("abort_rst_wr", fifo_wr_en_o, 0);
    chk("abort_rst_rdy", req_ready_o, 0);
    chk("abort_rst_gv", grant_valid_o, 0);
    chk("abort_rst_data", fifo_write_data_o, 0);
    next_cyc(); rst_n = 1'b1; req_valid_i = 4'b1010; req_last_i = 4'b1010;
    settle(); chk_idle("abort_idle");
    chk("abort_gid", grant_id_o, 0);
    next_cyc(); settle(); chk_beat("abort_regrant", 2'd1, 8'h82);
    next_cyc(); req_valid_i = '0; settle();
    chk("abort_qlen", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("abort_q0", wr_q[0], 8'h81);
      chk("abort_q1", wr_q[1], 8'h82);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter WIDTH, default 8: data word width, equal to the FIFO WIDTH.
REQ-003 SHALL have parameter MAX_BEATS, default 16: maximum words per grant, 1..256.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester word valid.
REQ-007 SHALL have port req_data_i  input  NUM_REQ*WIDTH  flattened words; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_last_i  input  NUM_REQ  per-requester packet-end flag, qualified by valid.
REQ-009 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept.
REQ-010 SHALL have port req_mask_i  input  NUM_REQ  per-requester arbitration enable; 1 = eligible.
REQ-011 SHALL have port fifo_full_i  input  1  full flag from the downstream FIFO.
REQ-012 SHALL have port fifo_wr_en_o  output  1  FIFO write enable.
REQ-013 SHALL have port fifo_write_data_o  output  WIDTH  FIFO write data.
REQ-014 SHALL have port grant_valid_o  output  1  a requester currently holds the grant.
REQ-015 SHALL have port grant_id_o  output  $clog2(NUM_REQ)  index of the granted requester.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-017 In IDLE: when (req_valid_i & req_mask_i) is nonzero, SHALL register as grant the first eligible index searching upward from (last_grant+1) mod NUM_REQ with wrap; SHALL clear beat_cnt; SHALL go to BUSY next cycle.
REQ-018 In IDLE: SHALL drive every req_ready_o bit 0 and fifo_wr_en_o 0; grant_valid_o SHALL be 0.
REQ-019 In BUSY: SHALL drive req_ready_o[grant] = !fifo_full_i and every other bit 0; grant_valid_o SHALL be 1.
REQ-020 Beat accepted = BUSY && req_valid_i[grant] && !fifo_full_i; fifo_wr_en_o SHALL equal beat accepted, combinationally.
REQ-021 fifo_write_data_o SHALL be the granted requester's word, combinationally; its value is don't-care when fifo_wr_en_o is 0.
REQ-022 On each accepted beat SHALL increment beat_cnt, width $clog2(MAX_BEATS+1).
REQ-023 When an accepted beat has req_last_i[grant]=1 or beat_cnt==MAX_BEATS-1, SHALL return to IDLE and set last_grant=grant.
REQ-024 SHALL remain in BUSY with beat_cnt held while the granted requester deasserts valid mid-packet; no timeout.
REQ-025 fifo_full_i asserted SHALL stall the transfer with no state change.
REQ-026 A mask change SHALL affect only the next arbitration; an active grant SHALL continue until its release condition.
REQ-027 There SHALL be exactly one IDLE cycle between consecutive grants, giving a minimum grant-to-grant gap of 1 cycle.
REQ-028 First-beat latency SHALL be 1 cycle: request seen in IDLE at cycle N, beat accepted no earlier than cycle N+1.

Reset
REQ-029 On rst_n=0 at a clock edge: state=IDLE, beat_cnt=0, grant_id_o=0, last_grant=NUM_REQ-1 so requester 0 has first priority.
REQ-030 During reset all outputs SHALL be 0: req_ready_o, fifo_wr_en_o, fifo_write_data_o, grant_valid_o.
REQ-031 Reset asserted mid-packet SHALL abort the grant without a further FIFO write; the partial packet remains in the FIFO.

Structure
REQ-032 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the pointer-width helper constant.
REQ-033 The round-robin search SHALL be a combinational sub-module rr_picker with inputs eligible and last_grant and outputs found and index.

Verification
REQ-034 Reset, then req_valid_i=4'b0101 held, all packets single-beat, mask=4'hF -> grants in order 0,2,0,2; one IDLE cycle between grants.
REQ-035 Requester 1 sends 3 words 0xA1,0xA2,0xA3 with last on 0xA3 while requester 3 is valid -> FIFO receives A1,A2,A3 contiguously, then requester 3 is granted.
REQ-036 Requester 0 streams with no last, MAX_BEATS=16 -> release after 16 writes; next grant goes to another valid requester.
REQ-037 fifo_full_i=1 for 5 cycles mid-packet -> fifo_wr_en_o=0 and req_ready_o=0 for those cycles; no data lost or duplicated.
REQ-038 mask=4'b1011 with only requester 2 valid -> no grant; set mask bit 2 -> grant_id_o=2 on the next cycle.
REQ-039 rst_n pulsed low during word 2 of a packet -> next cycle IDLE, all outputs 0, and the first subsequent grant goes to the lowest valid index.
